// File: rtl/sop_bank_pkg.sv
// Shared widths, issue-tag type and the round-robin helper for the SOP bank scheduler.
package sop_bank_pkg;
    localparam int LANES      = 8;
    localparam int LANE_IN_W  = 148;
    localparam int LANE_OUT_W = 37;
    localparam int IN_W       = LANES * LANE_IN_W;
    localparam int OUT_W      = LANES * LANE_OUT_W;
    localparam int ID_MAX_W   = 4;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } sop_tag_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction
endpackage

// File: rtl/sop_rsp_fifo.sv
// First-word-fall-through response FIFO with occupancy count; push and pop may coincide at any fill level.
module sop_rsp_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_s;

    assign pop_s = pop && (count_r != {CW{1'b0}});
    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;

    // Storage array, written at the tail on every push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/sop_bank_scheduler.sv
// Round-robin front end for a shared fixed-latency SOP bank; tags ride alongside the
// bank pipeline and results land in a credit-protected response FIFO.
module sop_bank_scheduler
    import sop_bank_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int LAT        = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int IN_W       = sop_bank_pkg::IN_W,
    parameter int OUT_W      = sop_bank_pkg::OUT_W,
    parameter int ID_W       = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*IN_W-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [IN_W-1:0]      bank_inp,
    input  logic [OUT_W-1:0]     bank_outp,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [OUT_W-1:0]     rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [ID_W-1:0] rr_r;
    logic [ID_W-1:0] winner_s;
    logic            found_s;
    logic            credit_ok_s;
    logic            handshake_s;
    logic            push_s;
    logic            pop_s;
    logic [CW-1:0]   fifo_count_s;
    logic [CW-1:0]   inflight_r;
    sop_tag_t        tag_r [LAT+1];

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        int idx;
        idx      = 0;
        winner_s = rr_r;
        found_s  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_r) + k) % NREQ;
            if (!found_s && req_valid[idx]) begin
                found_s  = 1'b1;
                winner_s = ID_W'(idx);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Outstanding issues plus buffered results must leave room for one more entry.
    assign credit_ok_s = ({1'b0, fifo_count_s} + {1'b0, inflight_r}) < SW'(FIFO_DEPTH);

    // Grant the winner only when a FIFO slot is guaranteed for its result.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (!reset && found_s && credit_ok_s) begin
            req_ready[winner_s] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    assign handshake_s = |(req_valid & req_ready);
    // Stage 0 pairs with bank_inp; stage LAT lines up with the matching bank_outp.
    assign push_s      = tag_r[LAT].valid;
    assign pop_s       = rsp_valid && rsp_ready;
    assign rsp_valid   = (fifo_count_s != {CW{1'b0}});
    assign busy        = (inflight_r != {CW{1'b0}}) || rsp_valid;

    // Arbitration pointer, operand register, tag pipeline and in-flight counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_r       <= {ID_W{1'b0}};
            bank_inp   <= {IN_W{1'b0}};
            inflight_r <= {CW{1'b0}};
            for (int i = 0; i <= LAT; i++) begin
                tag_r[i] <= '{valid: 1'b0, id: {ID_MAX_W{1'b0}}};
            end
        end else begin
            if (handshake_s) begin
                tag_r[0] <= '{valid: 1'b1, id: ID_MAX_W'(winner_s)};
                rr_r     <= ID_W'(rr_next(32'(winner_s), 32'(NREQ)));
                bank_inp <= req_data[int'(winner_s)*IN_W +: IN_W];
            end else begin
                tag_r[0] <= '{valid: 1'b0, id: {ID_MAX_W{1'b0}}};
            end
            for (int i = 1; i <= LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
            case ({handshake_s, push_s})
                2'b10:   inflight_r <= inflight_r + CW'(1);
                2'b01:   inflight_r <= inflight_r - CW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    sop_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ID_W + OUT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   ({tag_r[LAT].id[ID_W-1:0], bank_outp}),
        .pop   (pop_s),
        .dout  ({rsp_id, rsp_data}),
        .count (fifo_count_s)
    );
endmodule
